// File: rtl/uart_rx_read.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a one-entry output buffer.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_read #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  frame_err_o,
  output logic                  overrun_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic                  parity_err_o
`endif
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic                    rx_meta_q, rx_s_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    overrun_q, overrun_d;
  logic                    bit_end_c;
  logic                    commit_c;
`ifdef UART_RX_PARITY_EN
  logic                    parity_err_q, parity_err_d;
`endif

  // Mid-bit sample point once the counter has been re-aligned to the start-bit centre
  assign bit_end_c = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    commit_c    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s_q) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);
        if (bit_end_c) begin
          shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);
        if (bit_end_c) begin
          parity_err_d = (^shift_q) ^ rx_s_q;
          state_d      = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);
        if (bit_end_c) begin
          if (rx_s_q) begin
            commit_c = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // One-entry buffer: a commit into a full, unaccepted buffer is dropped
    if (commit_c) begin
      if (!valid_q || ready_out) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_out) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx_i;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_o      = data_q;
  assign valid_out   = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_read.sv
// Randomized bench for uart_rx_read: frames are scheduled as events and a buffer-level
// model predicts valid/data/flag outputs, compared every cycle on the falling edge.
module tb_uart_rx_read;

  localparam int CPB = 16;
  localparam int DW  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Start-drive edge to stop-bit mid-sample edge: sync (2) + idle detect (1) + half bit + bits
  localparam int LAT = 3 + CPB / 2 + 1 + CPB * (DW + 1 + PAR);

  logic          clk;
  logic          rstn;
  logic          rx_i;
  logic [DW-1:0] data_o;
  logic          valid_out;
  logic          ready_out;
  logic          frame_err_o;
  logic          overrun_o;
`ifdef UART_RX_PARITY_EN
  logic          parity_err_o;
`endif

  uart_rx_read #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_out   (valid_out),
    .ready_out   (ready_out),
    .frame_err_o (frame_err_o),
`ifdef UART_RX_PARITY_EN
    .parity_err_o(parity_err_o),
`endif
    .overrun_o   (overrun_o)
  );

  typedef struct {
    int            at;
    logic [DW-1:0] data;
    logic          stop_ok;
    logic          par_bad;
  } ev_t;

  ev_t           ev_q[$];
  int            edge_n = 0;
  int            start_edge = 0;
  int            n_chk = 0;
  int            n_err = 0;
  logic          rand_ready = 1'b0;
  logic          ready_force = 1'b1;
  logic          m_valid, m_fe, m_ov, m_pe;
  logic [DW-1:0] m_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Ready driver: random per cycle or a scenario-controlled level
  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      ready_out = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Reference model of the output buffer and flag pulses
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_fe    <= 1'b0;
      m_ov    <= 1'b0;
      m_pe    <= 1'b0;
    end else begin
      m_fe <= 1'b0;
      m_ov <= 1'b0;
      m_pe <= 1'b0;
      if (m_valid && ready_out) m_valid <= 1'b0;
      if (ev_q.size() != 0) begin
        if (ev_q[0].par_bad && (ev_q[0].at - CPB == edge_n + 1)) m_pe <= 1'b1;
        if (ev_q[0].at == edge_n + 1) begin
          if (!ev_q[0].stop_ok) m_fe <= 1'b1;
          else if (!m_valid || ready_out) begin
            m_data  <= ev_q[0].data;
            m_valid <= 1'b1;
          end else m_ov <= 1'b1;
          void'(ev_q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("data_o", 32'(data_o), 32'(m_data));
    check("frame_err_o", 32'(frame_err_o), 32'(m_fe));
    check("overrun_o", 32'(overrun_o), 32'(m_ov));
`ifdef UART_RX_PARITY_EN
    check("parity_err_o", 32'(parity_err_o), 32'(m_pe));
`endif
  end

  // Drives one frame; abort_bit >= 0 resets the DUT in the middle of that data bit
  task automatic send_frame(input logic [DW-1:0] b, input logic stop_bit, input logic par_flip,
                            input int abort_bit, input int hold_low);
    @(posedge clk);
    #1;
    start_edge = edge_n;
    ev_q.push_back('{at: edge_n + LAT, data: b, stop_ok: stop_bit, par_bad: par_flip});
    rx_i = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < DW; i++) begin
      #1 rx_i = b[i];
      if (i == abort_bit) begin
        repeat (CPB / 2) @(posedge clk);
        #1 rstn = 1'b0;
        ev_q.delete();
        rx_i = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_frame_err", 32'(frame_err_o), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (4) @(posedge clk);
        return;
      end
      repeat (CPB) @(posedge clk);
    end
`ifdef UART_RX_PARITY_EN
    #1 rx_i = (^b) ^ par_flip;
    repeat (CPB) @(posedge clk);
`endif
    #1 rx_i = stop_bit;
    repeat (CPB + hold_low) @(posedge clk);
    #1 rx_i = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    rx_i = 1'b1;
    repeat (5) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (5) @(posedge clk);

    // Clean frame with ready held high
    send_frame(8'hA5, 1'b1, 1'b0, -1, 0);
    repeat (CPB) @(posedge clk);

    // Short low glitch must be rejected
    #1 rx_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_i = 1'b1;
    repeat (3 * CPB) @(posedge clk);

    // Bad stop bit with the line held low, then a good frame
    send_frame(8'h3C, 1'b0, 1'b0, -1, 40 - CPB);
    send_frame(8'h11, 1'b1, 1'b0, -1, 0);

    // Overrun: second byte dropped while the first waits
    ready_force = 1'b0;
    send_frame(8'h01, 1'b1, 1'b0, -1, 0);
    send_frame(8'h02, 1'b1, 1'b0, -1, 0);
    repeat (CPB) @(posedge clk);
    ready_force = 1'b1;
    repeat (CPB) @(posedge clk);

    // Accept on the exact commit cycle: no bubble between bytes
    ready_force = 1'b0;
    send_frame(8'h01, 1'b1, 1'b0, -1, 0);
    fork
      send_frame(8'h02, 1'b1, 1'b0, -1, 0);
      begin
        #2;
        do begin
          @(posedge clk);
          #1;
        end while (edge_n < start_edge + LAT - 1);
        ready_force = 1'b1;
        @(posedge clk);
        #1 ready_force = 1'b0;
      end
    join
    repeat (CPB) @(posedge clk);
    ready_force = 1'b1;
    repeat (CPB) @(posedge clk);

    // Reset during data bit 3, then an intact frame (bad parity when enabled)
    send_frame(8'h55, 1'b1, 1'b0, 3, 0);
    send_frame(8'h7E, 1'b1, 1'(PAR), -1, 0);
    repeat (CPB) @(posedge clk);

    // Random frames, random stop quality, random downstream ready
    rand_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      logic [DW-1:0] b;
      logic          s_ok;
      b    = DW'($urandom);
      s_ok = ($urandom_range(0, 4) != 0);
      send_frame(b, s_ok, 1'($urandom_range(0, 1)) & 1'(PAR), -1,
                 s_ok ? 0 : int'($urandom_range(0, 30)));
      repeat ($urandom_range(0, 20)) @(posedge clk);
    end
    rand_ready = 1'b0;
    ready_force = 1'b1;
    repeat (3 * CPB) @(posedge clk);

    check("pending_frames", 32'(ev_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_read.md
UART_RX_READ -- requirements
Module: uart_rx_read

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 8, the number of data bits per frame.
REQ-002 The block SHALL provide parameter CLKS_PER_BIT, default 868, the number of clk cycles per serial bit period (minimum 4).
REQ-003 The block SHALL provide port clk, input, 1, the clock.
REQ-004 The block SHALL provide port rstn, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL provide port rx_i, input, 1, the asynchronous serial line, which idles high.
REQ-006 The block SHALL provide port data_o, output, DATA_WIDTH, the received byte.
REQ-007 The block SHALL provide port valid_out, output, 1, which indicates that data_o holds an unconsumed byte.
REQ-008 The block SHALL provide port ready_out, input, 1, the downstream accept signal.
REQ-009 The block SHALL provide port frame_err_o, output, 1, a 1-cycle pulse on a bad stop bit.
REQ-010 The block SHALL provide port overrun_o, output, 1, a 1-cycle pulse when a completed byte is dropped.
REQ-011 The block SHALL provide port parity_err_o, output, 1, a 1-cycle pulse on parity mismatch; it is present only with UART_RX_PARITY_EN.

Function
REQ-012 rx_i SHALL pass through a 2-flop synchronizer before any use; all timing below is relative to the synchronized signal (rx_s).
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY (macro only), STOP and WAIT_IDLE.
REQ-014 IDLE -> START SHALL occur on rx_s == 0; the bit counter is cleared.
REQ-015 In START, at count CLKS_PER_BIT/2 (integer division): rx_s == 0 SHALL go to DATA with the counter reset; rx_s == 1 SHALL treat the event as a glitch and return to IDLE with no flags.
REQ-016 In DATA, rx_s SHALL be sampled every CLKS_PER_BIT cycles after the start mid-point, LSB first, into a shift register; after DATA_WIDTH samples the FSM SHALL go to PARITY (macro) or STOP.
REQ-017 In STOP, the mid-bit sample equal to 1 SHALL commit the byte and return to IDLE.
REQ-018 In STOP, the mid-bit sample equal to 0 SHALL pulse frame_err_o, discard the byte, and go to WAIT_IDLE.
REQ-019 WAIT_IDLE SHALL go to IDLE on the first cycle rx_s == 1.
REQ-020 The cycle counter SHALL be $clog2(CLKS_PER_BIT) bits wide and wrap to 0 at CLKS_PER_BIT-1.
REQ-021 The one-entry output buffer SHALL work as follows: on commit, data_o SHALL load the byte and valid_out SHALL assert on the next cycle (latency: 1 clk after the stop-bit mid-sample).
REQ-022 valid_out and data_o SHALL remain stable until valid_out & ready_out; valid_out SHALL then deassert on the next cycle.
REQ-023 When a commit coincides with valid_out & ready_out, the new byte SHALL load and valid_out SHALL stay 1 with no gap.
REQ-024 When a commit occurs while valid_out == 1 and ready_out == 0, the new byte SHALL be dropped, the old byte kept, and overrun_o pulsed for 1 cycle.
REQ-025 valid_out SHALL never depend combinationally on ready_out.

Reset
REQ-026 On rstn low the FSM SHALL go to IDLE, the counters and shift register SHALL clear, valid_out SHALL be 0, data_o SHALL be 0, and frame_err_o, overrun_o and parity_err_o SHALL be 0.
REQ-027 The synchronizer flops SHALL reset to 1 (idle line).
REQ-028 Reset asserted mid-frame SHALL abort the frame; after release the block SHALL wait for a fresh falling edge, with no partial byte output.

Configuration
REQ-029 With UART_RX_PARITY_EN defined, an even-parity bit SHALL follow the data bits and be sampled in PARITY at mid-bit.
REQ-030 With UART_RX_PARITY_EN defined, a mismatch SHALL pulse parity_err_o; the byte is still committed if the stop bit is good.
REQ-031 Without UART_RX_PARITY_EN, the PARITY state and parity_err_o SHALL not exist, and the frame SHALL be start + DATA_WIDTH + stop.

Verification (CLKS_PER_BIT=16, DATA_WIDTH=8)
REQ-032 Scenario: frame 0xA5 with good stop and ready_out=1 -> valid_out high for 1 cycle, data_o=0xA5, no flags.
REQ-033 Scenario: 4-cycle low glitch on rx_i -> no valid_out, no flags, FSM back in IDLE.
REQ-034 Scenario: frame 0x3C with stop bit 0, line held low 40 cycles -> frame_err_o 1 pulse, no valid_out, next frame 0x11 received correctly.
REQ-035 Scenario: ready_out=0, frames 0x01 then 0x02 sent -> data_o=0x01 held, overrun_o 1 pulse at the 0x02 stop mid-point; ready_out=1 -> 0x01 delivered.
REQ-036 Scenario: ready_out pulsed in the same cycle as the 0x02 commit -> 0x01 accepted, then 0x02 valid with no idle cycle.
REQ-037 Scenario: rstn low during DATA bit 3 -> all outputs 0; the following frame 0x7E is received intact (with macro: a frame with a bad parity bit -> parity_err_o pulse and byte delivered).
